// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone slave-side decoder.
package wb_pkg;

    localparam int NSLV   = 4;
    localparam int SIDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_e;

    localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_S1_BASE = 32'h1000_0000;
    localparam logic [31:0] DEF_S2_BASE = 32'h2000_0000;
    localparam logic [31:0] DEF_S3_BASE = 32'h3000_0000;
    localparam logic [31:0] DEF_MASK    = 32'hF000_0000;

    // Index of the lowest set bit; lower slave indices win overlapping windows.
    function automatic logic [SIDX_W-1:0] lowest_index(input logic [NSLV-1:0] hits);
        logic [SIDX_W-1:0] idx;
        idx = {SIDX_W{1'b0}};
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hits[i]) begin
                idx = SIDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles while run is high, flags the last allowed cycle.
module wb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_s;
            assign unused_s = ^{clk, rst, clr, run};
            assign expired  = 1'b0;
        end else begin : g_on
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Next count: clear on request, saturate at TIMEOUT instead of wrapping.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = {CW{1'b0}};
                end else if (run && (cnt_q != CW'(TIMEOUT))) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end

            // Count register with synchronous reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= {CW{1'b0}};
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = run && (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wb_slave_decoder.sv
// Wishbone slave-side decoder: routes one master request to one of four slaves,
// terminating unmapped or hung transfers with err.
module wb_slave_decoder
    import wb_pkg::*;
#(
    parameter int           DW      = 32,
    parameter int           AW      = 32,
    parameter logic [AW-1:0] S0_BASE = AW'(DEF_S0_BASE),
    parameter logic [AW-1:0] S1_BASE = AW'(DEF_S1_BASE),
    parameter logic [AW-1:0] S2_BASE = AW'(DEF_S2_BASE),
    parameter logic [AW-1:0] S3_BASE = AW'(DEF_S3_BASE),
    parameter logic [AW-1:0] S0_MASK = AW'(DEF_MASK),
    parameter logic [AW-1:0] S1_MASK = AW'(DEF_MASK),
    parameter logic [AW-1:0] S2_MASK = AW'(DEF_MASK),
    parameter logic [AW-1:0] S3_MASK = AW'(DEF_MASK),
    parameter int           TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_cyc_i,
    input  logic              m_stb_i,
    input  logic              m_we_i,
    input  logic [AW-1:0]     m_adr_i,
    input  logic [DW-1:0]     m_dat_i,
    input  logic [DW/8-1:0]   m_sel_i,
    output logic [DW-1:0]     m_dat_o,
    output logic              m_ack_o,
    output logic              m_err_o,
    output logic [NSLV-1:0]   s_cyc_o,
    output logic [NSLV-1:0]   s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    input  logic [DW-1:0]     s0_dat_i,
    input  logic [DW-1:0]     s1_dat_i,
    input  logic [DW-1:0]     s2_dat_i,
    input  logic [DW-1:0]     s3_dat_i,
    input  logic [NSLV-1:0]   s_ack_i,
    input  logic [NSLV-1:0]   s_err_i
);

    localparam logic [AW-1:0] BASE_A [NSLV] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
    localparam logic [AW-1:0] MASK_A [NSLV] = '{S0_MASK, S1_MASK, S2_MASK, S3_MASK};

    state_e              state_q, state_d;
    logic [SIDX_W-1:0]   sel_idx_q, sel_idx_d;
    logic                we_q, we_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [DW-1:0]       dat_q, dat_d;
    logic [DW/8-1:0]     sel_q, sel_d;

    logic [NSLV-1:0]     hit_s;
    logic                hit_any_s;
    logic [SIDX_W-1:0]   hit_idx_s;
    logic                sel_ack_s;
    logic                sel_err_s;
    logic [DW-1:0]       sel_dat_s;
    logic                wd_clr_s;
    logic                wd_run_s;
    logic                wd_expired_s;

    // Address decode against every slave window.
    always_comb begin
        hit_s = {NSLV{1'b0}};
        for (int i = 0; i < NSLV; i++) begin
            hit_s[i] = ((m_adr_i & MASK_A[i]) == BASE_A[i]);
        end
        hit_any_s = |hit_s;
        hit_idx_s = lowest_index(hit_s);
    end

    // Response signals of the latched slave only; others are ignored.
    always_comb begin
        sel_ack_s = s_ack_i[sel_idx_q];
        sel_err_s = s_err_i[sel_idx_q];
        case (sel_idx_q)
            2'd0:    sel_dat_s = s0_dat_i;
            2'd1:    sel_dat_s = s1_dat_i;
            2'd2:    sel_dat_s = s2_dat_i;
            2'd3:    sel_dat_s = s3_dat_i;
            default: sel_dat_s = {DW{1'b0}};
        endcase
    end

    assign wd_clr_s = (state_q != ST_ACTIVE);
    assign wd_run_s = (state_q == ST_ACTIVE) && !sel_ack_s && !sel_err_s;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .run     (wd_run_s),
        .expired (wd_expired_s)
    );

    // Next-state and transfer-latch logic.
    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (hit_any_s) begin
                        sel_idx_d = hit_idx_s;
                        we_d      = m_we_i;
                        adr_d     = m_adr_i;
                        dat_d     = m_dat_i;
                        sel_d     = m_sel_i;
                        state_d   = ST_ACTIVE;
                    end else begin
                        state_d   = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // A slave response beats both an abort and a same-cycle expiry.
                if (sel_ack_s || sel_err_s) begin
                    state_d = ST_IDLE;
                end else if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (wd_expired_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched transfer fields, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_idx_q <= {SIDX_W{1'b0}};
            we_q      <= 1'b0;
            adr_q     <= {AW{1'b0}};
            dat_q     <= {DW{1'b0}};
            sel_q     <= {(DW/8){1'b0}};
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
        end
    end

    // Outputs decoded from state; slave responses pass straight through while ACTIVE.
    always_comb begin
        s_cyc_o = {NSLV{1'b0}};
        s_stb_o = {NSLV{1'b0}};
        m_ack_o = 1'b0;
        m_err_o = 1'b0;
        m_dat_o = {DW{1'b0}};
        case (state_q)
            ST_ACTIVE: begin
                s_cyc_o = {{(NSLV-1){1'b0}}, 1'b1} << sel_idx_q;
                s_stb_o = {{(NSLV-1){1'b0}}, 1'b1} << sel_idx_q;
                m_ack_o = sel_ack_s;
                m_err_o = sel_err_s && !sel_ack_s;
                m_dat_o = sel_dat_s;
            end
            ST_ERR: begin
                m_err_o = 1'b1;
            end
            default: begin
                m_err_o = 1'b0;
            end
        endcase
    end

    assign s_we_o  = we_q;
    assign s_adr_o = adr_q;
    assign s_dat_o = dat_q;
    assign s_sel_o = sel_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Self-checking bench for wb_slave_decoder: directed table, corner sequences,
// then random traffic against a transaction-level reference model.
module tb_wb_slave_decoder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc_i, m_stb_i, m_we_i;
    logic [31:0] m_adr_i, m_dat_i;
    logic [3:0]  m_sel_i;
    logic [31:0] m_dat_o;
    logic        m_ack_o, m_err_o;
    logic [3:0]  s_cyc_o, s_stb_o;
    logic        s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] sd [4];
    logic [3:0]  s_ack_i, s_err_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_slave_decoder #(.DW(32), .AW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s0_dat_i(sd[0]), .s1_dat_i(sd[1]), .s2_dat_i(sd[2]), .s3_dat_i(sd[3]),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i)
    );

    typedef struct {
        logic        cyc, stb, we;
        logic [31:0] adr, wdat;
        logic [3:0]  ack, err;
        logic [3:0]  e_stb;
        logic        e_ack, e_err;
        logic [31:0] e_dat;
        logic        e_we;
        logic [31:0] e_adr, e_wdat;
        logic [3:0]  e_sel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic cyc, stb, we, input logic [31:0] adr, wdat,
                                input logic [3:0] ack, err, e_stb,
                                input logic e_ack, e_err, input logic [31:0] e_dat,
                                input logic e_we, input logic [31:0] e_adr, e_wdat,
                                input logic [3:0] e_sel);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr; v.wdat = wdat;
        v.ack = ack; v.err = err; v.e_stb = e_stb; v.e_ack = e_ack; v.e_err = e_err;
        v.e_dat = e_dat; v.e_we = e_we; v.e_adr = e_adr; v.e_wdat = e_wdat; v.e_sel = e_sel;
        return v;
    endfunction

    function automatic logic [127:0] outs();
        return {17'd0, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_dat_o,
                s_we_o, s_adr_o, s_dat_o, s_sel_o};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic cyc, stb, we, input logic [31:0] adr,
                       input logic [3:0] ack, err);
        m_cyc_i = cyc; m_stb_i = stb; m_we_i = we; m_adr_i = adr;
        s_ack_i = ack; s_err_i = err;
    endtask

    // Reference model: one outstanding transfer, described at transaction level.
    int          m_cur;
    bit          m_errp;
    int          m_age;
    logic        m_we;
    logic [31:0] m_adr, m_wd;
    logic [3:0]  m_sel;

    task automatic model_reset();
        m_cur = -1; m_errp = 1'b0; m_age = 0;
        m_we = 1'b0; m_adr = 32'd0; m_wd = 32'd0; m_sel = 4'd0;
    endtask

    function automatic logic [127:0] model_expect();
        logic [3:0]  stb;
        logic        ack, err;
        logic [31:0] dat;
        stb = 4'd0; ack = 1'b0; err = 1'b0; dat = 32'd0;
        if (m_errp) begin
            err = 1'b1;
        end else if (m_cur >= 0) begin
            stb = 4'b0001 << m_cur;
            ack = s_ack_i[m_cur];
            err = s_err_i[m_cur] & ~ack;
            dat = sd[m_cur];
        end
        return {17'd0, stb, stb, ack, err, dat, m_we, m_adr, m_wd, m_sel};
    endfunction

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_errp) begin
            m_errp = 1'b0;
        end else if (m_cur >= 0) begin
            if (s_ack_i[m_cur] || s_err_i[m_cur]) m_cur = -1;
            else if (!m_cyc_i) m_cur = -1;
            else if (m_age == TO - 1) begin m_cur = -1; m_errp = 1'b1; end
            else m_age++;
        end else if (m_cyc_i && m_stb_i) begin
            if (m_adr_i[31:28] < 4) begin
                m_cur = int'(m_adr_i[31:28]); m_age = 0;
                m_we = m_we_i; m_adr = m_adr_i; m_wd = m_dat_i; m_sel = m_sel_i;
            end else begin
                m_errp = 1'b1;
            end
        end
    endtask

    initial begin
        logic [31:0] Z;
        logic [3:0]  ackv, errv;
        Z = 32'd0;

        // Directed table: one row per clock cycle.
        // read slave 2, ack two cycles after its strobe
        tbl.push_back(mk(1,1,0,32'h2000_0010,Z, 4'h0,4'h0, 4'h0,0,0,Z,            0,Z,Z,4'h0));
        tbl.push_back(mk(1,1,0,32'h2000_0010,Z, 4'h0,4'h0, 4'h4,0,0,32'hDEAD_BEEF,0,32'h2000_0010,Z,4'hF));
        tbl.push_back(mk(1,1,0,32'h2000_0010,Z, 4'h0,4'h0, 4'h4,0,0,32'hDEAD_BEEF,0,32'h2000_0010,Z,4'hF));
        tbl.push_back(mk(1,1,0,32'h2000_0010,Z, 4'h4,4'h0, 4'h4,1,0,32'hDEAD_BEEF,0,32'h2000_0010,Z,4'hF));
        tbl.push_back(mk(0,0,0,Z,Z,             4'h0,4'h0, 4'h0,0,0,Z,            0,32'h2000_0010,Z,4'hF));
        // write slave 0, immediate ack
        tbl.push_back(mk(1,1,1,32'h0000_0004,32'h1234_5678, 4'h0,4'h0, 4'h0,0,0,Z,0,32'h2000_0010,Z,4'hF));
        tbl.push_back(mk(1,1,1,32'h0000_0004,32'h1234_5678, 4'h1,4'h0, 4'h1,1,0,32'h0000_AAAA,1,32'h0000_0004,32'h1234_5678,4'hF));
        tbl.push_back(mk(0,0,0,Z,Z, 4'h0,4'h0, 4'h0,0,0,Z,1,32'h0000_0004,32'h1234_5678,4'hF));
        // unmapped address
        tbl.push_back(mk(1,1,0,32'h8000_0000,Z, 4'h0,4'h0, 4'h0,0,0,Z,1,32'h0000_0004,32'h1234_5678,4'hF));
        tbl.push_back(mk(1,1,0,32'h8000_0000,Z, 4'h0,4'h0, 4'h0,0,1,Z,1,32'h0000_0004,32'h1234_5678,4'hF));
        tbl.push_back(mk(0,0,0,Z,Z,             4'h0,4'h0, 4'h0,0,0,Z,1,32'h0000_0004,32'h1234_5678,4'hF));
        // slave 3 ack and err together
        tbl.push_back(mk(1,1,0,32'h3000_0000,Z, 4'h0,4'h0, 4'h0,0,0,Z,1,32'h0000_0004,32'h1234_5678,4'hF));
        tbl.push_back(mk(1,1,0,32'h3000_0000,Z, 4'h8,4'h8, 4'h8,1,0,32'h3333_3333,0,32'h3000_0000,Z,4'hF));
        tbl.push_back(mk(0,0,0,Z,Z,             4'h0,4'h0, 4'h0,0,0,Z,0,32'h3000_0000,Z,4'hF));
        // unselected slave 0 responds while slave 3 is active
        tbl.push_back(mk(1,1,0,32'h3000_0100,Z, 4'h0,4'h0, 4'h0,0,0,Z,0,32'h3000_0000,Z,4'hF));
        tbl.push_back(mk(1,1,0,32'h3000_0100,Z, 4'h1,4'h1, 4'h8,0,0,32'h3333_3333,0,32'h3000_0100,Z,4'hF));
        tbl.push_back(mk(1,1,0,32'h3000_0100,Z, 4'h8,4'h0, 4'h8,1,0,32'h3333_3333,0,32'h3000_0100,Z,4'hF));
        tbl.push_back(mk(0,0,0,Z,Z,             4'h0,4'h0, 4'h0,0,0,Z,0,32'h3000_0100,Z,4'hF));
        // slave 1 terminates with err
        tbl.push_back(mk(1,1,0,32'h1000_0000,Z, 4'h0,4'h0, 4'h0,0,0,Z,0,32'h3000_0100,Z,4'hF));
        tbl.push_back(mk(1,1,0,32'h1000_0000,Z, 4'h0,4'h2, 4'h2,0,1,32'h1111_1111,0,32'h1000_0000,Z,4'hF));
        tbl.push_back(mk(0,0,0,Z,Z,             4'h0,4'h0, 4'h0,0,0,Z,0,32'h1000_0000,Z,4'hF));

        sd[0] = 32'h0000_AAAA; sd[1] = 32'h1111_1111; sd[2] = 32'hDEAD_BEEF; sd[3] = 32'h3333_3333;
        rst = 1'b1; m_dat_i = 32'd0; m_sel_i = 4'hF;
        drv(0, 0, 0, Z, 4'h0, 4'h0);
        nxt();
        #2 chk("reset_state", outs(), 128'd0);
        nxt();
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].ack, tbl[i].err);
            m_dat_i = tbl[i].wdat;
            #2 chk($sformatf("table_row%0d", i), outs(),
                   {17'd0, tbl[i].e_stb, tbl[i].e_stb, tbl[i].e_ack, tbl[i].e_err, tbl[i].e_dat,
                    tbl[i].e_we, tbl[i].e_adr, tbl[i].e_wdat, tbl[i].e_sel});
            nxt();
        end
        m_dat_i = 32'd0;

        // Hung slave 1: err after TO active cycles, late ack ignored.
        drv(1, 1, 0, 32'h1000_0000, 4'h0, 4'h0);
        nxt();
        for (int k = 0; k < TO; k++) begin
            #2 chk("hung_active", {s_stb_o, m_err_o}, {4'b0010, 1'b0});
            nxt();
        end
        s_ack_i = 4'b0010;
        #2 chk("hung_err", {s_stb_o, m_ack_o, m_err_o}, {4'b0000, 1'b0, 1'b1});
        nxt();
        drv(0, 0, 0, Z, 4'h0, 4'h0);
        #2 chk("hung_idle", {s_stb_o, m_ack_o, m_err_o}, 6'd0);
        nxt();

        // Ack arrives on the expiry cycle: plain ack, no err afterwards.
        drv(1, 1, 0, 32'h1000_0000, 4'h0, 4'h0);
        nxt();
        for (int k = 0; k < TO - 1; k++) nxt();
        s_ack_i = 4'b0010;
        #2 chk("expiry_ack", {s_stb_o, m_ack_o, m_err_o}, {4'b0010, 1'b1, 1'b0});
        nxt();
        drv(0, 0, 0, Z, 4'h0, 4'h0);
        #2 chk("expiry_after", {s_stb_o, m_ack_o, m_err_o}, 6'd0);
        nxt();

        // Master abort while ACTIVE.
        drv(1, 1, 0, 32'h0000_0100, 4'h0, 4'h0);
        nxt();
        #2 chk("abort_active", {s_cyc_o, s_stb_o}, {4'b0001, 4'b0001});
        nxt();
        drv(0, 0, 0, Z, 4'h0, 4'h0);
        nxt();
        #2 chk("abort_idle", {s_cyc_o, s_stb_o, m_ack_o, m_err_o}, 10'd0);
        nxt();
        #2 chk("abort_quiet", {s_cyc_o, s_stb_o, m_ack_o, m_err_o}, 10'd0);
        nxt();

        // Reset in the middle of a transfer.
        drv(1, 1, 1, 32'h2000_0040, 4'h0, 4'h0);
        m_dat_i = 32'h0000_0055;
        nxt();
        #2 chk("rst_active", {28'd0, s_stb_o}, 32'h0000_0004);
        rst = 1'b1;
        nxt();
        #2 chk("rst_outputs", outs(), 128'd0);
        rst = 1'b0;
        drv(0, 0, 0, Z, 4'h0, 4'h0);
        nxt();

        // Random traffic against the reference model.
        rst = 1'b1;
        #2;
        model_step();
        nxt();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            m_cyc_i = (m_cur >= 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) != 0);
            m_stb_i = m_cyc_i & ($urandom_range(0, 3) != 0);
            m_we_i  = 1'($urandom_range(0, 1));
            m_adr_i = {4'($urandom_range(0, 5)), 28'($urandom)};
            m_dat_i = $urandom;
            m_sel_i = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) begin
                ackv[b] = ($urandom_range(0, 7) == 0);
                errv[b] = ($urandom_range(0, 31) == 0);
                sd[b]   = $urandom;
            end
            s_ack_i = ackv;
            s_err_i = errv;
            rst = ($urandom_range(0, 299) == 0);
            #2 chk("random", outs(), model_expect());
            model_step();
            nxt();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
